qos_csr_slave: RTL

QOS_CSR_SLAVE -- requirements
Module: qos_csr_slave

---
 rtl/qos_csr_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/qos_csr_slave.sv
// qos_csr_slave: memory-mapped CSR slave for channel QoS configuration and status.
//
// Register map:
//   0x00 CONFIG (RW): [0] fallback_enable, [1] manual_enable, [3:2] manual_channel,
//                     [11:4] channel_priority, [31:12] reset_timer
//   0x01 STATUS (RO): [1:0] active_channel, [5:2] sig_present, [6] cfg_err
//   0x02 LOSS   (RO): {cnt4, cnt3, cnt2, cnt1}, saturating 8-bit loss counters
//   Unmapped addresses read as zero; writes to them are ignored.
//
// Ports:
//   rclk, rst_n        clock, asynchronous active-low reset
//   mm_write_en/read_en, mm_addr, mm_wdata  register access, one request per cycle
//   mm_rdata           registered read data, 1-cycle latency, held until the next read
//   active_channel, sig_present, loss_pulse  status inputs (rclk-synchronous)
//   fallback_enable, manual_enable, manual_channel, channel_priority, reset_timer
//                      CONFIG fields
//   cfg_update         one-cycle pulse after an accepted CONFIG write
//
// Optional feature: define QOS_CSR_CLEAR_ON_READ_EN to clear the loss counters when
// LOSS is read. Without it the counters clear only on reset.

module qos_csr_slave #(
  parameter logic [19:0] RST_TIMER    = 20'd2250,
  parameter logic [7:0]  RST_PRIORITY = 8'b11_10_01_00
) (
  input  logic        rclk,
  input  logic        rst_n,
  input  logic        mm_write_en,
  input  logic        mm_read_en,
  input  logic [7:0]  mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  input  logic [1:0]  active_channel,
  input  logic [3:0]  sig_present,
  input  logic [3:0]  loss_pulse,
  output logic        fallback_enable,
  output logic        manual_enable,
  output logic [1:0]  manual_channel,
  output logic [7:0]  channel_priority,
  output logic [19:0] reset_timer,
  output logic        cfg_update
);

  localparam logic [7:0] AddrConfig = 8'h00;
  localparam logic [7:0] AddrStatus = 8'h01;
  localparam logic [7:0] AddrLoss   = 8'h02;

  logic        r_fallback;
  logic        r_manual;
  logic [1:0]  r_manual_ch;
  logic [7:0]  r_prio;
  logic [19:0] r_timer;
  logic        r_cfg_err;
  logic        r_cfg_update;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt [4];

  logic        w_cfg_wr;
  logic        w_loss_rd;
  logic        w_clr_on_rd;
  logic [3:0]  w_seen;
  logic        w_perm;
  logic [31:0] w_config;
  logic [31:0] w_status;
  logic [31:0] w_loss;
  logic [31:0] w_rdata;

  assign w_cfg_wr  = mm_write_en && (mm_addr == AddrConfig);
  assign w_loss_rd = mm_read_en && (mm_addr == AddrLoss);

`ifdef QOS_CSR_CLEAR_ON_READ_EN
  assign w_clr_on_rd = w_loss_rd;
`else
  assign w_clr_on_rd = 1'b0;
`endif

  // Four 2-bit fields form a permutation of 0..3 exactly when every value is seen.
  always_comb begin
    w_seen = '0;
    for (int i = 0; i < 4; i++) begin
      w_seen[mm_wdata[4 + 2*i +: 2]] = 1'b1;
    end
    w_perm = &w_seen;
  end

  assign w_config = {r_timer, r_prio, r_manual_ch, r_manual, r_fallback};
  assign w_status = {25'd0, r_cfg_err, sig_present, active_channel};
  assign w_loss   = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};

  // Read mux sees pre-edge register state, so a read-with-write returns the old CONFIG.
  always_comb begin
    w_rdata = 32'd0;
    unique case (mm_addr)
      AddrConfig: w_rdata = w_config;
      AddrStatus: w_rdata = w_status;
      AddrLoss:   w_rdata = w_loss;
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fallback   <= 1'b1;
      r_manual     <= 1'b0;
      r_manual_ch  <= 2'd0;
      r_prio       <= RST_PRIORITY;
      r_timer      <= RST_TIMER;
      r_cfg_err    <= 1'b0;
      r_cfg_update <= 1'b0;
    end else begin
      r_cfg_update <= w_cfg_wr;
      if (w_cfg_wr) begin
        r_fallback  <= mm_wdata[0];
        r_manual    <= mm_wdata[1];
        r_manual_ch <= mm_wdata[3:2];
        r_prio      <= mm_wdata[11:4];
        r_timer     <= mm_wdata[31:12];
        r_cfg_err   <= !w_perm;
      end
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
    end else if (mm_read_en) begin
      r_rdata <= w_rdata;
    end
  end

  // A pulse coinciding with a clearing read counts into the freshly cleared counter.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_clr_on_rd) begin
          r_cnt[i] <= {7'd0, loss_pulse[i]};
        end else if (loss_pulse[i] && (r_cnt[i] != 8'hFF)) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign mm_rdata         = r_rdata;
  assign fallback_enable  = r_fallback;
  assign manual_enable    = r_manual;
  assign manual_channel   = r_manual_ch;
  assign channel_priority = r_prio;
  assign reset_timer      = r_timer;
  assign cfg_update       = r_cfg_update;

endmodule
